// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the two-requester ALU share arbiter.
// Holds the controller state enum, default widths and a lane helper.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SEL_W_DEF  = 2;
  localparam int REQ_N      = 2;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [REQ_N-1:0] lane_onehot(
    input logic g
  );
    return g ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker.
// Ports: req_i (requests), ptr_i (preferred lane), gnt_o (one-hot), any_o.
module alu_rr_pick2
  import alu_ctrl_pkg::*;
(
  input  logic [REQ_N-1:0] req_i,
  input  logic             ptr_i,
  output logic [REQ_N-1:0] gnt_o,
  output logic             any_o
);

  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = lane_onehot(ptr_i);
      default: gnt_o = '0;
    endcase
  end

  assign any_o = |req_i;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU slice between two requesters, one op in flight.
// Ports: wb_clk_i/wb_rst_ni, req_* channel, rsp_* channel, alu_* pins, busy_o.
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [2*DATA_W-1:0]   req_a_i,
  input  logic [2*DATA_W-1:0]   req_b_i,
  input  logic [2*SEL_W-1:0]    req_sel_i,
  output logic [1:0]            rsp_valid_o,
  input  logic [1:0]            rsp_ready_i,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  rsp_carry_o,
  output logic [DATA_W-1:0]     alu_a_o,
  output logic [DATA_W-1:0]     alu_b_o,
  output logic [SEL_W-1:0]      alu_sel_o,
  input  logic [DATA_W-1:0]     alu_out_i,
  input  logic                  alu_carry_i,
  output logic                  busy_o
);

  localparam logic [CNT_W-1:0] LAT_M1 =
    CNT_W'(ALU_LAT - 1);

  state_e              state_q;
  logic                owner_q;
  logic                ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [SEL_W-1:0]    sel_q;
  logic [DATA_W-1:0]   res_q;
  logic                carry_q;

  logic [1:0]          gnt;
  logic                any;
  logic                win;
  logic                idle;
  logic                resp;
  logic [DATA_W-1:0]   a_d;
  logic [DATA_W-1:0]   b_d;
  logic [SEL_W-1:0]    sel_d;

  alu_rr_pick2 u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .any_o (any)
  );

  assign idle = (state_q == IDLE);
  assign resp = (state_q == RESP);
  assign win  = gnt[1];

  assign a_d = win ? req_a_i[2*DATA_W-1:DATA_W]
                   : req_a_i[DATA_W-1:0];
  assign b_d = win ? req_b_i[2*DATA_W-1:DATA_W]
                   : req_b_i[DATA_W-1:0];
  assign sel_d = win ? req_sel_i[2*SEL_W-1:SEL_W]
                     : req_sel_i[SEL_W-1:0];

  // Reset is synchronous, so mask handshake outputs while it is held.
  assign req_ready_o = (idle && wb_rst_ni) ? gnt : 2'b00;
  assign rsp_valid_o = (resp && wb_rst_ni)
                     ? lane_onehot(owner_q) : 2'b00;
  assign rsp_data_o  = (resp && wb_rst_ni) ? res_q : '0;
  assign rsp_carry_o = resp && wb_rst_ni && carry_q;

  assign alu_a_o   = a_q;
  assign alu_b_o   = b_q;
  assign alu_sel_o = sel_q;
  assign busy_o    = !idle;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            owner_q <= win;
            ptr_q   <= ~win;
            cnt_q   <= LAT_M1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            res_q   <= alu_out_i;
            carry_q <= alu_carry_i;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i[owner_q]) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a transaction-level model.
// A bench-side ALU closes the loop on the alu_* pins.
module tb_alu_share_arbiter;

  localparam int DW  = 8;
  localparam int SW  = 2;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid = 2'b00;
  logic [1:0]    req_ready;
  logic [2*DW-1:0] req_a = '0;
  logic [2*DW-1:0] req_b = '0;
  logic [2*SW-1:0] req_sel = '0;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready = 2'b00;
  logic [DW-1:0] rsp_data;
  logic          rsp_carry;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [SW-1:0] alu_sel;
  logic [DW-1:0] alu_out;
  logic          alu_carry;
  logic          busy;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(
    .DATA_W (DW),
    .SEL_W  (SW),
    .ALU_LAT(LAT)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_a_i    (req_a),
    .req_b_i    (req_b),
    .req_sel_i  (req_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_carry_o(rsp_carry),
    .alu_a_o    (alu_a),
    .alu_b_o    (alu_b),
    .alu_sel_o  (alu_sel),
    .alu_out_i  (alu_out),
    .alu_carry_i(alu_carry),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] s
  );
    case (s)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(
    input string       name,
    input logic [15:0] act,
    input logic [15:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: an op is in flight from accept until its response is taken;
  // the response becomes visible LAT+1 cycles after the accept cycle.
  logic       m_known = 1'b0;
  logic       m_busy;
  logic       m_own;
  logic       m_pref;
  int         m_due;
  int         cyc = 0;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [1:0] m_sel;
  logic [7:0] m_res;
  logic       m_c;

  always @(negedge clk) begin
    logic [1:0] e_rdy;
    logic [1:0] e_rv;
    logic [8:0] r;
    int         g;
    cyc++;
    e_rdy = 2'b00;
    e_rv  = 2'b00;
    if (m_known) begin
      if (rst_n && !m_busy) begin
        if (req_valid == 2'b11)
          e_rdy = m_pref ? 2'b10 : 2'b01;
        else
          e_rdy = req_valid;
      end
      if (rst_n && m_busy && cyc >= m_due)
        e_rv = m_own ? 2'b10 : 2'b01;
      chk("m_req_ready", 16'(req_ready), 16'(e_rdy));
      chk("m_rsp_valid", 16'(rsp_valid), 16'(e_rv));
      chk("m_rsp_data", 16'(rsp_data),
          16'((e_rv != 0) ? m_res : 8'h00));
      chk("m_rsp_carry", 16'(rsp_carry),
          16'((e_rv != 0) && m_c));
      chk("m_busy", 16'(busy), 16'(m_busy));
      chk("m_alu_a", 16'(alu_a), 16'(m_a));
      chk("m_alu_b", 16'(alu_b), 16'(m_b));
      chk("m_alu_sel", 16'(alu_sel), 16'(m_sel));
    end
    if (!rst_n) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_own   = 1'b0;
      m_pref  = 1'b0;
      m_due   = 0;
      m_a     = '0;
      m_b     = '0;
      m_sel   = '0;
      m_res   = '0;
      m_c     = 1'b0;
    end else if (m_known) begin
      if (e_rdy != 2'b00) begin
        g      = e_rdy[1] ? 1 : 0;
        m_a    = req_a[g*DW +: DW];
        m_b    = req_b[g*DW +: DW];
        m_sel  = req_sel[g*SW +: SW];
        r      = alu_f(m_a, m_b, m_sel);
        m_res  = r[7:0];
        m_c    = r[8];
        m_busy = 1'b1;
        m_own  = e_rdy[1];
        m_pref = ~e_rdy[1];
        m_due  = cyc + LAT + 1;
      end else if (e_rv != 2'b00 && rsp_ready[m_own]) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic cb();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(
    input int         g,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] s
  );
    req_a[g*DW +: DW]   = a;
    req_b[g*DW +: DW]   = b;
    req_sel[g*SW +: SW] = s;
  endtask

  task automatic wait_rsp(input logic [1:0] want);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!hit) begin
        cb();
        @(negedge clk);
        hit = (rsp_valid == want);
      end
    end
    chk("wait_rsp", 16'(rsp_valid), 16'(want));
  endtask

  task automatic wait_ready(input logic [1:0] want);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!hit) begin
        cb();
        @(negedge clk);
        hit = (req_ready == want);
      end
    end
    chk("wait_ready", 16'(req_ready), 16'(want));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gq[$];
    int tq[$];

    // reset held with both requesters valid
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_req(0, 8'hF0, 8'h20, 2'b00);
    set_req(1, 8'h11, 8'h22, 2'b00);
    cb();
    cb();
    @(negedge clk);
    chk("rst_ready", 16'(req_ready), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_rsp", 16'(rsp_valid), 16'h0);
    chk("rst_alu_a", 16'(alu_a), 16'h0);

    // release: requester 0 preferred, single add
    cb();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 16'(req_ready), 16'h1);
    cb();
    req_valid = 2'b00;
    @(negedge clk);
    chk("op_busy", 16'(busy), 16'h1);
    chk("op_rsp0", 16'(rsp_valid), 16'h0);
    cb();
    @(negedge clk);
    chk("op_rsp", 16'(rsp_valid), 16'h1);
    chk("op_data", 16'(rsp_data), 16'h10);
    chk("op_carry", 16'(rsp_carry), 16'h1);

    // contention: both saturate
    cb();
    set_req(0, 8'hAA, 8'h55, 2'b11);
    set_req(1, 8'hFF, 8'h0F, 2'b10);
    req_valid = 2'b11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        gq.push_back(req_ready[1] ? 1 : 0);
        tq.push_back(i);
      end
      if (rsp_valid == 2'b01) begin
        chk("ct_d0", 16'(rsp_data), 16'hFF);
        chk("ct_c0", 16'(rsp_carry), 16'h0);
      end
      if (rsp_valid == 2'b10) begin
        chk("ct_d1", 16'(rsp_data), 16'h0F);
        chk("ct_c1", 16'(rsp_carry), 16'h0);
      end
      cb();
    end
    req_valid = 2'b00;
    chk("ct_ngrant", 16'(gq.size()), 16'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gq.size()) begin
        chk("ct_who", 16'(gq[i]), 16'((i % 2 == 0) ? 1 : 0));
        chk("ct_when", 16'(tq[i]), 16'(3 * i));
      end
    end

    // response backpressure from owner 1
    cb();
    set_req(1, 8'h3C, 8'hC3, 2'b00);
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_acc", 16'(req_ready), 16'h2);
    cb();
    set_req(0, 8'h80, 8'h80, 2'b00);
    req_valid = 2'b01;
    @(negedge clk);
    chk("bp_exec", 16'(req_ready), 16'h0);
    cb();
    @(negedge clk);
    chk("bp_rv", 16'(rsp_valid), 16'h2);
    chk("bp_d", 16'(rsp_data), 16'hFF);
    for (int i = 0; i < 5; i++) begin
      cb();
      rsp_ready = (i < 3) ? 2'b00 : 2'b01;
      @(negedge clk);
      chk("bp_hold_rv", 16'(rsp_valid), 16'h2);
      chk("bp_hold_d", 16'(rsp_data), 16'hFF);
      chk("bp_hold_rdy", 16'(req_ready), 16'h0);
    end
    cb();
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_hs", 16'(rsp_valid), 16'h2);
    cb();
    rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_next", 16'(req_ready), 16'h1);
    cb();
    req_valid = 2'b00;
    @(negedge clk);
    chk("no_busy", 16'(busy), 16'h1);
    // owner 0 with only the non-owner ready
    for (int i = 0; i < 3; i++) begin
      cb();
      @(negedge clk);
      chk("no_rv", 16'(rsp_valid), 16'h1);
      chk("no_d", 16'(rsp_data), 16'h00);
      chk("no_c", 16'(rsp_carry), 16'h1);
    end
    cb();
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("no_hs", 16'(rsp_valid), 16'h1);
    cb();
    @(negedge clk);
    chk("no_idle", 16'(busy), 16'h0);

    // reset in the middle of an op
    cb();
    set_req(0, 8'h12, 8'h34, 2'b00);
    req_valid = 2'b01;
    @(negedge clk);
    chk("mr_acc", 16'(req_ready), 16'h1);
    cb();
    req_valid = 2'b00;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_exec", 16'(busy), 16'h1);
    cb();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_busy", 16'(busy), 16'h0);
    for (int i = 0; i < 3; i++) begin
      cb();
      @(negedge clk);
      chk("mr_norsp", 16'(rsp_valid), 16'h0);
    end
    cb();
    set_req(0, 8'hAA, 8'h55, 2'b11);
    set_req(1, 8'h05, 8'h06, 2'b01);
    req_valid = 2'b11;
    @(negedge clk);
    chk("mr_ptr", 16'(req_ready), 16'h1);
    cb();
    req_valid = 2'b10;
    wait_ready(2'b10);
    cb();
    req_valid = 2'b00;
    wait_rsp(2'b10);
    chk("mr_d", 16'(rsp_data), 16'hFF);
    chk("mr_c", 16'(rsp_carry), 16'h1);
    cb();
    cb();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
